// File: rtl/jtcontra_layermix.sv
// Multi-layer colour mixer: frame-latched priority, per-layer enables,
// dual-port palette RAM and a 4-stage pixel pipeline with aligned blanking.
module jtcontra_layermix #(
    parameter int NLAYER = 2,
    parameter int PXLW   = 7,
    parameter int COLW   = 5,
    localparam int LW    = (NLAYER == 2) ? 1 : 2,
    localparam int PALW  = LW + PXLW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    input  logic [NLAYER*PXLW-1:0] pxl_in,
    input  logic [NLAYER*LW-1:0]   prio_order,
    input  logic [NLAYER-1:0]      layer_en,
    input  logic                   pal_cs,
    input  logic                   cpu_rnw,
    input  logic                   cpu_cen,
    input  logic [PALW:0]          cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    output logic [COLW-1:0]        red,
    output logic [COLW-1:0]        green,
    output logic [COLW-1:0]        blue
);

    localparam int NSLOT = 2**LW;

    function automatic logic [NLAYER*LW-1:0] identity_order();
        logic [NLAYER*LW-1:0] o;
        o = '0;
        for (int k = 0; k < NLAYER; k++) o[k*LW +: LW] = LW'(k);
        return o;
    endfunction

    localparam logic [NLAYER*LW-1:0] ORDER_ID = identity_order();

    logic [7:0]             pal_lo [0:2**PALW-1];
    logic [7:0]             pal_hi [0:2**PALW-1];
    logic [PALW-1:0]        cpu_entry;

    logic [NLAYER*LW-1:0]   order_act;
    logic [NLAYER*PXLW-1:0] pxl_s1;
    logic [NLAYER-1:0]      en_s1;
    logic                   lhbl_s1, lvbl_s1, lhbl_s2, lvbl_s2, lhbl_s3, lvbl_s3;
    logic [PALW-1:0]        addr_s2;
    logic [14:0]            entry_s3;

    logic [PXLW-1:0]        layer_pix [0:NSLOT-1];
    logic [NSLOT-1:0]       opaque;
    logic [LW-1:0]          win_idx;
    logic [PXLW-1:0]        win_pxl;
    logic                   blank;

    assign cpu_entry = cpu_addr[PALW:1];

    // Palette storage is never cleared by reset
    always_ff @(posedge clk) begin
        if (pal_cs && !cpu_rnw && cpu_cen) begin
            if (cpu_addr[0]) pal_hi[cpu_entry] <= cpu_dout;
            else             pal_lo[cpu_entry] <= cpu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         pal_dout <= '0;
        else if (pal_cs) pal_dout <= cpu_addr[0] ? pal_hi[cpu_entry] : pal_lo[cpu_entry];
    end

    // S1 capture; the order latches on the first tick of vertical blank
    always_ff @(posedge clk) begin
        if (rst) begin
            pxl_s1    <= '0;
            en_s1     <= '0;
            lhbl_s1   <= 1'b0;
            lvbl_s1   <= 1'b0;
            order_act <= ORDER_ID;
        end else if (pxl_cen) begin
            pxl_s1  <= pxl_in;
            en_s1   <= layer_en;
            lhbl_s1 <= LHBL;
            lvbl_s1 <= LVBL;
            if (!LVBL && lvbl_s1) order_act <= prio_order;
        end
    end

    // Out-of-range layer indices read as a transparent zero pixel
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            layer_pix[k] = '0;
            opaque[k]    = 1'b0;
        end
        for (int k = 0; k < NLAYER; k++) begin
            layer_pix[k] = pxl_s1[k*PXLW +: PXLW];
            opaque[k]    = en_s1[k] && (pxl_s1[k*PXLW +: 4] != 4'd0);
        end
        win_idx = order_act[(NLAYER-1)*LW +: LW];
        for (int s = NLAYER-1; s >= 0; s--) begin
            if (opaque[order_act[s*LW +: LW]]) win_idx = order_act[s*LW +: LW];
        end
        win_pxl = layer_pix[win_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_s2  <= '0;
            lhbl_s2  <= 1'b0;
            lvbl_s2  <= 1'b0;
            entry_s3 <= '0;
            lhbl_s3  <= 1'b0;
            lvbl_s3  <= 1'b0;
        end else if (pxl_cen) begin
            addr_s2  <= {win_idx, win_pxl};
            lhbl_s2  <= lhbl_s1;
            lvbl_s2  <= lvbl_s1;
            entry_s3 <= {pal_hi[addr_s2][6:0], pal_lo[addr_s2]};
            lhbl_s3  <= lhbl_s2;
            lvbl_s3  <= lvbl_s2;
        end
    end

    assign blank = !(lhbl_s3 && lvbl_s3);

    always_ff @(posedge clk) begin
        if (rst) begin
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (pxl_cen) begin
            red      <= blank ? '0 : entry_s3[4  -: COLW];
            green    <= blank ? '0 : entry_s3[9  -: COLW];
            blue     <= blank ? '0 : entry_s3[14 -: COLW];
            LHBL_dly <= lhbl_s3;
            LVBL_dly <= lvbl_s3;
        end
    end

endmodule

// File: tb/tb_jtcontra_layermix.sv
// Bench for jtcontra_layermix: directed scenarios plus a per-cycle comparison
// against a tick-history model of the mixer and palette.
module tb_jtcontra_layermix;

    localparam int NLAYER = 2;
    localparam int PXLW   = 7;
    localparam int COLW   = 5;
    localparam int LW     = 1;
    localparam int PALW   = 8;

    logic                   clk, rst, pxl_cen, LHBL, LVBL, LHBL_dly, LVBL_dly;
    logic [NLAYER*PXLW-1:0] pxl_in;
    logic [NLAYER*LW-1:0]   prio_order;
    logic [NLAYER-1:0]      layer_en;
    logic                   pal_cs, cpu_rnw, cpu_cen;
    logic [PALW:0]          cpu_addr;
    logic [7:0]             cpu_dout, pal_dout;
    logic [COLW-1:0]        red, green, blue;

    jtcontra_layermix #(.NLAYER(NLAYER), .PXLW(PXLW), .COLW(COLW)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .pxl_in(pxl_in),
        .prio_order(prio_order), .layer_en(layer_en), .pal_cs(pal_cs),
        .cpu_rnw(cpu_rnw), .cpu_cen(cpu_cen), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .pal_dout(pal_dout), .red(red), .green(green),
        .blue(blue)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        pxl_cen = 1'b0;
        forever begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                pxl_cen = (c == 3);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: per-tick history of addresses and blanks, palette image
    logic [15:0]     pal_m [0:2**PALW-1];
    int              ord_m [NLAYER];
    logic            prev_v;
    int              t, win;
    int              hist_addr [0:4095];
    logic            hist_h [0:4095];
    logic            hist_v [0:4095];
    logic [15:0]     col_at [0:4095];
    logic [15:0]     e, w;
    logic [COLW-1:0] exp_r, exp_g, exp_b;
    logic            exp_h, exp_v;
    logic [7:0]      exp_dout;
    logic            model_on = 1'b0;
    logic            init_done = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            t = 0; prev_v = 1'b0;
            for (int s = 0; s < NLAYER; s++) ord_m[s] = s;
            exp_r = '0; exp_g = '0; exp_b = '0; exp_h = 1'b0; exp_v = 1'b0;
            exp_dout = '0; model_on = 1'b1;
        end else begin
            if (pxl_cen) begin
                if (!LVBL && prev_v)
                    for (int s = 0; s < NLAYER; s++) ord_m[s] = int'(prio_order[s*LW +: LW]);
                prev_v = LVBL;
                win = -1;
                for (int s = 0; s < NLAYER; s++)
                    if (win < 0 && layer_en[ord_m[s]] && pxl_in[ord_m[s]*PXLW +: 4] != 4'd0)
                        win = ord_m[s];
                if (win < 0) win = ord_m[NLAYER-1];
                hist_addr[t & 4095] = win * (2**PXLW) + int'(pxl_in[win*PXLW +: PXLW]);
                hist_h[t & 4095] = LHBL;
                hist_v[t & 4095] = LVBL;
                if (t >= 2) col_at[t & 4095] = pal_m[hist_addr[(t-2) & 4095]];
                if (t >= 3) begin
                    e = col_at[(t-1) & 4095];
                    exp_h = hist_h[(t-3) & 4095];
                    exp_v = hist_v[(t-3) & 4095];
                    if (exp_h && exp_v) begin
                        exp_r = e[4:0]; exp_g = e[9:5]; exp_b = e[14:10];
                    end else begin
                        exp_r = '0; exp_g = '0; exp_b = '0;
                    end
                end
                t++;
            end
            if (pal_cs) begin
                w = pal_m[cpu_addr[PALW:1]];
                exp_dout = cpu_addr[0] ? w[15:8] : w[7:0];
            end
            if (pal_cs && !cpu_rnw && cpu_cen) begin
                w = pal_m[cpu_addr[PALW:1]];
                if (cpu_addr[0]) w[15:8] = cpu_dout;
                else             w[7:0]  = cpu_dout;
                pal_m[cpu_addr[PALW:1]] = w;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            checkOutput("cyc red", int'(red), int'(exp_r));
            checkOutput("cyc green", int'(green), int'(exp_g));
            checkOutput("cyc blue", int'(blue), int'(exp_b));
            checkOutput("cyc LHBL_dly", int'(LHBL_dly), int'(exp_h));
            checkOutput("cyc LVBL_dly", int'(LVBL_dly), int'(exp_v));
            if (init_done) checkOutput("cyc pal_dout", int'(pal_dout), int'(exp_dout));
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL timeout: got running expected finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!pxl_cen);
        end
        @(negedge clk);
    endtask

    task automatic cpu_write(input int addr, input logic [7:0] data);
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1;
        cpu_addr = (PALW+1)'(addr); cpu_dout = data;
        @(negedge clk);
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
    endtask

    task automatic cpu_read(input int addr);
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = (PALW+1)'(addr);
        @(negedge clk);
        pal_cs = 1'b0;
    endtask

    task automatic write_entry(input int ent, input logic [15:0] val);
        cpu_write(ent*2, val[7:0]);
        cpu_write(ent*2 + 1, val[15:8]);
    endtask

    task automatic applyStimulus(input logic [13:0] px, input logic [1:0] en);
        pxl_in = px; layer_en = en;
    endtask

    task automatic check_rgb(input string name, input int r, input int g, input int b);
        checkOutput({name, " red"}, int'(red), r);
        checkOutput({name, " green"}, int'(green), g);
        checkOutput({name, " blue"}, int'(blue), b);
    endtask

    task automatic vblank_pulse();
        LVBL = 1'b0;
        wait_ticks(2);
        LVBL = 1'b1;
    endtask

    int low_cnt, first_low, lit_cnt;

    initial begin
        rst = 1'b1; LHBL = 1'b0; LVBL = 1'b1; pxl_in = '0; prio_order = 2'b10;
        layer_en = 2'b11; pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
        cpu_addr = '0; cpu_dout = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 2*(2**PALW); i++) cpu_write(i, 8'(i) ^ 8'hA5);
        init_done = 1'b1;
        write_entry(8'h05, 16'h5143);
        write_entry(8'hA3, 16'h24B1);
        write_entry(8'hB0, 16'h07E0);
        write_entry(8'h23, 16'h1CE7);
        LHBL = 1'b1;

        // Palette byte write and readback
        cpu_write(9'h010, 8'h1F);
        cpu_write(9'h011, 8'h7C);
        cpu_read(9'h011);
        checkOutput("t1 read 0x11", int'(pal_dout), 8'h7C);
        cpu_read(9'h010);
        checkOutput("t1 read 0x10", int'(pal_dout), 8'h1F);
        @(negedge clk);
        checkOutput("t1 hold", int'(pal_dout), 8'h1F);

        // Two-layer priority with identity order
        applyStimulus({7'h23, 7'h05}, 2'b11);
        wait_ticks(6);
        check_rgb("t2 entry05", 3, 10, 20);
        applyStimulus({7'h23, 7'h00}, 2'b11);
        wait_ticks(6);
        check_rgb("t2 entryA3", 17, 5, 9);

        // Order change takes effect only from vertical blank
        applyStimulus({7'h23, 7'h05}, 2'b11);
        wait_ticks(6);
        prio_order = 2'b01;
        wait_ticks(8);
        check_rgb("t3 midframe", 3, 10, 20);
        vblank_pulse();
        wait_ticks(6);
        check_rgb("t3 after vbl", 17, 5, 9);

        // Disabled layer and backdrop from the bottom slot
        prio_order = 2'b10;
        vblank_pulse();
        applyStimulus({7'h30, 7'h05}, 2'b10);
        wait_ticks(6);
        check_rgb("t4 backdrop", 0, 31, 1);

        // Horizontal blank window of 10 ticks
        applyStimulus({7'h23, 7'h05}, 2'b11);
        wait_ticks(6);
        low_cnt = 0; first_low = -1; lit_cnt = 0;
        LHBL = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_ticks(1);
            if (i == 9) LHBL = 1'b1;
            if (!LHBL_dly) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
                if (red != 0 || green != 0 || blue != 0) lit_cnt++;
            end
        end
        checkOutput("t5 low ticks", low_cnt, 10);
        checkOutput("t5 first low", first_low, 3);
        checkOutput("t5 rgb in blank", lit_cnt, 0);

        // Mid-line reset flushes pipeline and restores identity order
        prio_order = 2'b01;
        vblank_pulse();
        wait_ticks(6);
        check_rgb("t6 before rst", 17, 5, 9);
        prio_order = 2'b10;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_rgb("t6 in rst", 0, 0, 0);
        checkOutput("t6 pal_dout rst", int'(pal_dout), 0);
        wait_ticks(3);
        check_rgb("t6 flushing", 0, 0, 0);
        checkOutput("t6 LHBL_dly flushing", int'(LHBL_dly), 0);
        wait_ticks(3);
        check_rgb("t6 identity", 3, 10, 20);
        cpu_read(9'h011);
        checkOutput("t6 palette kept", int'(pal_dout), 8'h7C);

        wait_ticks(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
